// File: rtl/uart_rx_sipo_param_if.sv
// Receiver-side bundle: line/enable/ack inputs and the deframed payload with status.
interface uart_rx_sipo_param_if #(
  parameter int unsigned DATA_BITS = 8
);
  logic                 rx_enable;
  logic                 data_tx;
  logic                 rx_ack;
  logic                 active_flag;
  logic                 recieved_flag;
  logic [DATA_BITS-1:0] data_parll;
  logic                 parity_err;
  logic                 frame_err;
  logic                 overrun_err;

  // Upstream/consumer side: drives the line and handshake, observes results.
  modport master (
    output rx_enable, data_tx, rx_ack,
    input  active_flag, recieved_flag, data_parll, parity_err, frame_err, overrun_err
  );

  // Receiver side.
  modport slave (
    input  rx_enable, data_tx, rx_ack,
    output active_flag, recieved_flag, data_parll, parity_err, frame_err, overrun_err
  );
endinterface

// File: rtl/uart_rx_sipo_param.sv
// Parametrised UART receiver: 3-sample majority vote per bit, false-start rejection,
// configurable data width / parity / stop bits, flag+ack handshake with overrun status.
module uart_rx_sipo_param #(
  parameter int unsigned DATA_BITS   = 8,
  parameter int unsigned PARITY_MODE = 0,
  parameter int unsigned STOP_BITS   = 1,
  parameter int unsigned OVERSAMPLE  = 16
) (
  input logic                 baud_clk,
  input logic                 reset,
  uart_rx_sipo_param_if.slave rx_if
);
  localparam int unsigned TICK_W = $clog2(OVERSAMPLE);
  localparam int unsigned BIT_W  = $clog2(DATA_BITS + 1);
  localparam int unsigned MID    = OVERSAMPLE / 2;

  localparam logic [TICK_W-1:0] T_S0   = TICK_W'(MID - 1);
  localparam logic [TICK_W-1:0] T_S1   = TICK_W'(MID);
  localparam logic [TICK_W-1:0] T_VOTE = TICK_W'(MID + 1);
  localparam logic [TICK_W-1:0] T_LAST = TICK_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0]  LAST_DATA = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0]  LAST_STOP = BIT_W'(STOP_BITS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t               state_q, state_d;
  logic [TICK_W-1:0]    tick_q, tick_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic [1:0]           samp_q, samp_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 perr_f_q, perr_f_d;
  logic                 ferr_f_q, ferr_f_d;
  logic                 active_q, active_d;
  logic                 flag_q, flag_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic                 ovr_q, ovr_d;
  logic                 vote_c;
  logic                 par_c;
  logic                 complete_c;

  // State and output registers.
  always_ff @(posedge baud_clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      tick_q   <= '0;
      bit_q    <= '0;
      samp_q   <= '0;
      shift_q  <= '0;
      perr_f_q <= 1'b0;
      ferr_f_q <= 1'b0;
      active_q <= 1'b0;
      flag_q   <= 1'b0;
      data_q   <= '0;
      perr_q   <= 1'b0;
      ferr_q   <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      tick_q   <= tick_d;
      bit_q    <= bit_d;
      samp_q   <= samp_d;
      shift_q  <= shift_d;
      perr_f_q <= perr_f_d;
      ferr_f_q <= ferr_f_d;
      active_q <= active_d;
      flag_q   <= flag_d;
      data_q   <= data_d;
      perr_q   <= perr_d;
      ferr_q   <= ferr_d;
      ovr_q    <= ovr_d;
    end
  end

  // Bit timing, voting, deframing and handshake next-state logic.
  always_comb begin
    state_d    = state_q;
    tick_d     = tick_q;
    bit_d      = bit_q;
    samp_d     = samp_q;
    shift_d    = shift_q;
    perr_f_d   = perr_f_q;
    ferr_f_d   = ferr_f_q;
    flag_d     = flag_q;
    data_d     = data_q;
    perr_d     = perr_q;
    ferr_d     = ferr_q;
    ovr_d      = ovr_q;
    complete_c = 1'b0;

    // Majority of the two stored samples and the live third sample.
    vote_c = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_if.data_tx) | (samp_q[1] & rx_if.data_tx);
    par_c  = (^shift_q) ^ vote_c;

    if (state_q != IDLE) begin
      tick_d = (tick_q == T_LAST) ? '0 : tick_q + TICK_W'(1);
      if (tick_q == T_S0) samp_d[0] = rx_if.data_tx;
      if (tick_q == T_S1) samp_d[1] = rx_if.data_tx;
    end

    unique case (state_q)
      IDLE: begin
        if (rx_if.rx_enable && !rx_if.data_tx) begin
          state_d  = START;
          tick_d   = '0;
          bit_d    = '0;
          perr_f_d = 1'b0;
          ferr_f_d = 1'b0;
        end
      end
      START: begin
        if (tick_q == T_VOTE && vote_c) begin
          state_d = IDLE;
          tick_d  = '0;
        end else if (tick_q == T_LAST) begin
          state_d = DATA;
        end
      end
      DATA: begin
        if (tick_q == T_VOTE) shift_d = {vote_c, shift_q[DATA_BITS-1:1]};
        if (tick_q == T_LAST) begin
          if (bit_q == LAST_DATA) begin
            bit_d   = '0;
            state_d = (PARITY_MODE != 0) ? PARITY : STOP;
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end
      end
      PARITY: begin
        if (tick_q == T_VOTE) perr_f_d = (PARITY_MODE == 2) ? ~par_c : par_c;
        if (tick_q == T_LAST) state_d = STOP;
      end
      STOP: begin
        if (tick_q == T_VOTE) begin
          if (!vote_c) ferr_f_d = 1'b1;
          // Final stop bit completes mid-bit so a following start edge is not missed.
          if (bit_q == LAST_STOP) begin
            complete_c = 1'b1;
            state_d    = IDLE;
            tick_d     = '0;
          end
        end else if (tick_q == T_LAST) begin
          bit_d = bit_q + BIT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Completion beats ack; an ack on the completion edge consumes the previous frame.
    if (complete_c) begin
      data_d = shift_q;
      perr_d = perr_f_q;
      ferr_d = ferr_f_q | ~vote_c;
      flag_d = 1'b1;
      ovr_d  = rx_if.rx_ack ? 1'b0 : (ovr_q | flag_q);
    end else if (rx_if.rx_ack) begin
      flag_d = 1'b0;
      ovr_d  = 1'b0;
    end

    active_d = (state_d != IDLE);
  end

  assign rx_if.active_flag   = active_q;
  assign rx_if.recieved_flag = flag_q;
  assign rx_if.data_parll    = data_q;
  assign rx_if.parity_err    = perr_q;
  assign rx_if.frame_err     = ferr_q;
  assign rx_if.overrun_err   = ovr_q;
endmodule

// File: tb/tb_uart_rx_sipo_param.sv
// Directed bench for uart_rx_sipo_param: an 8N1 and an 8E1 instance share the line.
module tb_uart_rx_sipo_param;
  localparam int OVS = 16;
  localparam int MID = OVS / 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic line = 1'b1;
  logic ack = 1'b0;
  logic en_n = 1'b0;
  logic en_e = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  logic act_log [0:255];
  logic flag_log [0:255];

  always #5 clk = ~clk;

  uart_rx_sipo_param_if #(.DATA_BITS(8)) if_n ();
  uart_rx_sipo_param_if #(.DATA_BITS(8)) if_e ();

  assign if_n.data_tx   = line;
  assign if_n.rx_ack    = ack;
  assign if_n.rx_enable = en_n;
  assign if_e.data_tx   = line;
  assign if_e.rx_ack    = ack;
  assign if_e.rx_enable = en_e;

  uart_rx_sipo_param #(.DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1), .OVERSAMPLE(OVS)) dut_n (
    .baud_clk(clk), .reset(rst), .rx_if(if_n)
  );
  uart_rx_sipo_param #(.DATA_BITS(8), .PARITY_MODE(1), .STOP_BITS(1), .OVERSAMPLE(OVS)) dut_e (
    .baud_clk(clk), .reset(rst), .rx_if(if_e)
  );

  typedef struct {
    string      name;
    int         dut;
    logic [7:0] data;
    logic       par;
    logic       stop;
    int         inv_bit;
    int         inv_lo;
    int         inv_hi;
    logic [7:0] exp_data;
    logic       exp_perr;
    logic       exp_ferr;
  } vec_t;

  vec_t vecs [8];

  function automatic logic [7:0] o_data(int w);
    return (w != 0) ? if_e.data_parll : if_n.data_parll;
  endfunction
  function automatic logic o_flag(int w);
    return (w != 0) ? if_e.recieved_flag : if_n.recieved_flag;
  endfunction
  function automatic logic o_act(int w);
    return (w != 0) ? if_e.active_flag : if_n.active_flag;
  endfunction
  function automatic logic o_perr(int w);
    return (w != 0) ? if_e.parity_err : if_n.parity_err;
  endfunction
  function automatic logic o_ferr(int w);
    return (w != 0) ? if_e.frame_err : if_n.frame_err;
  endfunction
  function automatic logic o_ovr(int w);
    return (w != 0) ? if_e.overrun_err : if_n.overrun_err;
  endfunction

  // Frame bit vector: index 0 is the start bit, then data LSB first, optional parity, stop.
  function automatic logic [15:0] mk_bits(logic [7:0] d, bit has_par, logic par, logic stop);
    logic [15:0] b;
    b = 16'hFFFF;
    b[0] = 1'b0;
    for (int i = 0; i < 8; i++) b[1 + i] = d[i];
    if (has_par) begin
      b[9]  = par;
      b[10] = stop;
    end else begin
      b[9] = stop;
    end
    return b;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Drives the line for edges E0+0 .. E0+n_edges-1, logging outputs after each edge.
  task automatic run_edges(input int w, input logic [15:0] bits, input int inv_bit,
                           input int inv_lo, input int inv_hi, input int ack_at, input int n_edges);
    for (int k = 0; k < n_edges; k++) begin
      logic v;
      int   n;
      int   t;
      if (k == 0) begin
        v = 1'b0;
      end else begin
        n = (k - 1) / OVS;
        t = (k - 1) % OVS;
        v = bits[n];
        if (n == inv_bit && t >= inv_lo && t <= inv_hi) v = ~v;
      end
      line = v;
      ack  = (k == ack_at);
      @(posedge clk);
      @(negedge clk);
      act_log[k]  = o_act(w);
      flag_log[k] = o_flag(w);
    end
    ack = 1'b0;
  endtask

  task automatic ack_pulse();
    @(negedge clk);
    ack = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ack = 1'b0;
  endtask

  initial begin
    int kc_n;
    vecs[0] = '{"n_a5",      0, 8'hA5, 1'b0, 1'b1, -1, 0, 0, 8'hA5, 1'b0, 1'b0};
    vecs[1] = '{"n_vote1",   0, 8'h00, 1'b0, 1'b1,  4, 8, 8, 8'h00, 1'b0, 1'b0};
    vecs[2] = '{"n_vote2",   0, 8'h00, 1'b0, 1'b1,  4, 7, 8, 8'h08, 1'b0, 1'b0};
    vecs[3] = '{"n_ferr",    0, 8'hFF, 1'b0, 1'b0, -1, 0, 0, 8'hFF, 1'b0, 1'b1};
    vecs[4] = '{"n_5a",      0, 8'h5A, 1'b0, 1'b1, -1, 0, 0, 8'h5A, 1'b0, 1'b0};
    vecs[5] = '{"e_perr",    1, 8'h3C, 1'b1, 1'b1, -1, 0, 0, 8'h3C, 1'b1, 1'b0};
    vecs[6] = '{"e_ferr",    1, 8'h3C, 1'b0, 1'b0, -1, 0, 0, 8'h3C, 1'b0, 1'b1};
    vecs[7] = '{"e_01_ok",   1, 8'h01, 1'b1, 1'b1, -1, 0, 0, 8'h01, 1'b0, 1'b0};
    kc_n = 1 + 9 * OVS + MID + 1;

    // Reset state.
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int w = 0; w < 2; w++) begin
      chk("rst_act",  32'(o_act(w)),  32'd0);
      chk("rst_flag", 32'(o_flag(w)), 32'd0);
      chk("rst_data", 32'(o_data(w)), 32'd0);
      chk("rst_ovr",  32'(o_ovr(w)),  32'd0);
    end

    // Table-driven frames.
    for (int i = 0; i < 8; i++) begin
      vec_t v;
      int   kc;
      v  = vecs[i];
      kc = 1 + ((v.dut != 0) ? 10 : 9) * OVS + MID + 1;
      en_n = (v.dut == 0);
      en_e = (v.dut != 0);
      line = 1'b1;
      ack_pulse();
      repeat (2) @(negedge clk);
      run_edges(v.dut, mk_bits(v.data, v.dut != 0, v.par, v.stop),
                v.inv_bit, v.inv_lo, v.inv_hi, -1, kc + 1);
      line = 1'b1;
      chk({v.name, "_act0"},     32'(act_log[0]),      32'd1);
      chk({v.name, "_flag_pre"}, 32'(flag_log[kc-1]),  32'd0);
      chk({v.name, "_act_pre"},  32'(act_log[kc-1]),   32'd1);
      chk({v.name, "_flag"},     32'(flag_log[kc]),    32'd1);
      chk({v.name, "_act_post"}, 32'(act_log[kc]),     32'd0);
      chk({v.name, "_data"},     32'(o_data(v.dut)),   32'(v.exp_data));
      chk({v.name, "_perr"},     32'(o_perr(v.dut)),   32'(v.exp_perr));
      chk({v.name, "_ferr"},     32'(o_ferr(v.dut)),   32'(v.exp_ferr));
      chk({v.name, "_ovr"},      32'(o_ovr(v.dut)),    32'd0);
      ack_pulse();
      chk({v.name, "_ack_flag"}, 32'(o_flag(v.dut)),   32'd0);
      chk({v.name, "_ack_data"}, 32'(o_data(v.dut)),   32'(v.exp_data));
    end

    // Glitch rejection: start low for 4 ticks then high.
    en_n = 1'b1;
    en_e = 1'b0;
    repeat (2) @(negedge clk);
    run_edges(0, 16'hFFFE, 0, 4, 15, -1, 16);
    chk("glitch_act_e9",  32'(act_log[9]),  32'd1);
    chk("glitch_act_e10", 32'(act_log[10]), 32'd0);
    chk("glitch_flag",    32'(o_flag(0)),   32'd0);
    chk("glitch_data",    32'(o_data(0)),   32'h5A);

    // Back-to-back without ack: overrun.
    repeat (2) @(negedge clk);
    run_edges(0, mk_bits(8'h11, 1'b0, 1'b0, 1'b1), -1, 0, 0, -1, kc_n + 1);
    chk("b2b1_flag", 32'(o_flag(0)), 32'd1);
    chk("b2b1_data", 32'(o_data(0)), 32'h11);
    run_edges(0, mk_bits(8'h22, 1'b0, 1'b0, 1'b1), -1, 0, 0, -1, kc_n + 1);
    line = 1'b1;
    chk("b2b2_act0", 32'(act_log[0]), 32'd1);
    chk("b2b2_data", 32'(o_data(0)),  32'h22);
    chk("b2b2_flag", 32'(o_flag(0)),  32'd1);
    chk("b2b2_ovr",  32'(o_ovr(0)),   32'd1);

    // Back-to-back with ack on the second completion edge.
    ack_pulse();
    chk("ack_clr_ovr", 32'(o_ovr(0)), 32'd0);
    run_edges(0, mk_bits(8'h11, 1'b0, 1'b0, 1'b1), -1, 0, 0, -1, kc_n + 1);
    run_edges(0, mk_bits(8'h22, 1'b0, 1'b0, 1'b1), -1, 0, 0, kc_n, kc_n + 1);
    line = 1'b1;
    chk("b2b_ack_data", 32'(o_data(0)), 32'h22);
    chk("b2b_ack_flag", 32'(o_flag(0)), 32'd1);
    chk("b2b_ack_ovr",  32'(o_ovr(0)),  32'd0);

    // Reset during data bit 4, then a clean frame.
    run_edges(0, mk_bits(8'h5A, 1'b0, 1'b0, 1'b1), -1, 0, 0, -1, 1 + 5 * OVS + 4);
    chk("mid_act_before", 32'(o_act(0)), 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_act",  32'(o_act(0)),  32'd0);
    chk("mid_rst_flag", 32'(o_flag(0)), 32'd0);
    chk("mid_rst_data", 32'(o_data(0)), 32'd0);
    chk("mid_rst_ferr", 32'(o_ferr(0)), 32'd0);
    line = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    run_edges(0, mk_bits(8'h5A, 1'b0, 1'b0, 1'b1), -1, 0, 0, -1, kc_n + 1);
    line = 1'b1;
    chk("post_rst_flag_pre", 32'(flag_log[kc_n-1]), 32'd0);
    chk("post_rst_flag",     32'(o_flag(0)),        32'd1);
    chk("post_rst_data",     32'(o_data(0)),        32'h5A);
    chk("post_rst_ferr",     32'(o_ferr(0)),        32'd0);
    chk("post_rst_ovr",      32'(o_ovr(0)),         32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
